ultrasonic_scheduler: RTL and testbench
=======================================

ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 500, trigger high time in clk_50M cycles (10 us).
REQ-002 SHALL have parameter WINDOW_CYCLES, default 3500000, echo listen window per sensor (70 ms).
REQ-003 SHALL have parameter GAP_CYCLES, default 50000, holdoff between sensors (1 ms).
REQ-004 SHALL have parameter ALERT_THRESH, default 1200, alert pulse-count threshold.
REQ-005 SHALL have ports: clk_50M in 1 system clock; reset in 1 synchronous active-low reset.
REQ-006 SHALL have ports: enable in 1 run scheduling; sensor_mask in 4 bit i=1 enables sensor i; echo_rx in 4 raw echo lines.
REQ-007 SHALL have ports: trigger out 4 per-sensor trigger; dist_data out 22 echo-high cycle count; dist_id out 2 sensor index of result; dist_valid out 1 result strobe; timeout out 1 no-echo flag; active_id out 2 sensor being serviced; state out 2 FSM state; alert out 4 per-sensor alert (macro-dependent, REQ-023).

Function
REQ-008 SHALL pass each echo_rx bit through a 2-flop synchronizer; all echo decisions use synchronized values (2-cycle latency).
REQ-009 SHALL implement FSM IDLE=00, TRIG=01, MEASURE=10, GAP=11, exposed on state.
REQ-010 IDLE: when enable=1 and sensor_mask!=0, SHALL load active_id with lowest unmasked index at or after current active_id (wrapping) and go TRIG; otherwise stay IDLE.
REQ-011 TRIG: SHALL drive trigger[active_id]=1, all other trigger bits 0, for exactly TRIG_CYCLES cycles, then go MEASURE with cycle and pulse counters cleared.
REQ-012 MEASURE: SHALL increment cycle counter every cycle and pulse counter every cycle synchronized echo[active_id]=1; pulse counter saturates at 22'h3FFFFF.
REQ-013 MEASURE: on synchronized falling edge of echo[active_id] with pulse counter>0, SHALL register dist_data=pulse count, dist_id=active_id, timeout=0, pulse dist_valid one cycle, go GAP.
REQ-014 MEASURE: when cycle counter reaches WINDOW_CYCLES-1 without REQ-013, SHALL emit dist_valid with timeout=1, dist_data=pulse count, go GAP; REQ-013 wins if both in same cycle.
REQ-015 Echoes on non-active sensors SHALL be ignored.
REQ-016 GAP: after GAP_CYCLES cycles SHALL select next unmasked index after active_id (3 wraps to 0); go TRIG if enable=1 and mask!=0, else IDLE.
REQ-017 Deasserting enable or changing sensor_mask mid-sequence SHALL NOT abort the current sensor; takes effect at GAP exit.
REQ-018 dist_data, dist_id, timeout SHALL hold until next dist_valid.
REQ-019 At most one trigger bit SHALL be high in any cycle.

Reset
REQ-020 When reset=0 at clk_50M edge, SHALL set state=IDLE, trigger=0, dist_data=0, dist_id=0, dist_valid=0, timeout=0, active_id=0, alert=0, all counters and synchronizers 0.
REQ-021 Reset mid-TRIG SHALL drop trigger on that same edge; no dist_valid is produced for the aborted sensor.

Configuration
REQ-022 Macro ULTRASONIC_SCHED_ALERT_EN SHALL control alert logic.
REQ-023 With macro: on each dist_valid, alert[dist_id] SHALL update to 1 if timeout=0 and dist_data>ALERT_THRESH, else 0; other bits hold. Without macro: alert SHALL be tied 4'b0 and no comparator synthesized.

Structure
REQ-024 Package ultrasonic_sched_pkg SHALL hold state encodings, default timing constants, and NUM_SENSORS=4.
REQ-025 Sub-module us_echo_timer SHALL contain synchronizer-selected echo edge detect, cycle and pulse counters, saturation, and done/timeout generation; one instance shared by all sensors.

Verification (bench overrides TRIG_CYCLES=10, WINDOW_CYCLES=2000, GAP_CYCLES=50)
REQ-026 mask=4'b1111, enable=1, sensor 0 echo high 300 cycles -> trigger[0] high 10 cycles; dist_valid, dist_id=0, dist_data=300, timeout=0.
REQ-027 mask=4'b1010, no echoes -> service order 1,3,1,3; each dist_valid with timeout=1 exactly 2000 cycles after MEASURE entry.
REQ-028 Echo on sensor 2 while sensor 1 active -> no effect on dist_data; sensor 1 result unchanged.
REQ-029 enable drops during MEASURE of sensor 0 -> sensor 0 result reported, FSM enters IDLE after GAP, trigger stays 0.
REQ-030 reset=0 asserted mid-TRIG -> trigger=0 and state=00 after that edge; no dist_valid.
REQ-031 Macro defined, sensor 2 echo 1500 cycles then 800 cycles on next visit -> alert[2]=1 then 0; macro undefined -> alert=0 throughout.

Source files
------------

// File: rtl/ultrasonic_sched_pkg.sv
// Shared types and constants for the four-channel ultrasonic ranging scheduler.
package ultrasonic_sched_pkg;

   localparam int unsigned NUM_SENSORS = 4;
   localparam int unsigned ID_W        = 2;
   localparam int unsigned CNT_W       = 22;

   // Default timing at a 50 MHz clock.
   localparam int unsigned DEF_TRIG_CYCLES   = 500;      // 10 us
   localparam int unsigned DEF_WINDOW_CYCLES = 3500000;  // 70 ms
   localparam int unsigned DEF_GAP_CYCLES    = 50000;    // 1 ms
   localparam int unsigned DEF_ALERT_THRESH  = 1200;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StTrig    = 2'b01,
      StMeasure = 2'b10,
      StGap     = 2'b11
   } sched_state_e;

   // Round-robin search for the next enabled sensor. With incl set the search starts at cur,
   // otherwise just after it; an empty mask returns cur unchanged.
   function automatic logic [ID_W-1:0] next_sensor(input logic [ID_W-1:0]        cur,
                                                   input logic [NUM_SENSORS-1:0] mask,
                                                   input logic                   incl);
      logic [ID_W-1:0] idx;
      logic            found;
      next_sensor = cur;
      found       = 1'b0;
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
         idx = cur + ID_W'(i) + ID_W'(!incl);
         if (!found && mask[idx]) begin
            next_sensor = idx;
            found       = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/us_echo_timer.sv
// Echo measurement engine shared by all sensors: synchronizes the raw echo lines, follows the
// selected channel, counts window cycles and echo-high cycles, and flags completion or timeout.
module us_echo_timer
   import ultrasonic_sched_pkg::*;
#(
   parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
   input  logic                   clk_50M,
   input  logic                   reset,
   input  logic [NUM_SENSORS-1:0] echo_rx_i,
   input  logic [ID_W-1:0]        sel_id_i,
   input  logic                   start_i,     // clear counters for a new window
   input  logic                   run_i,       // measurement window open
   output logic                   done_o,
   output logic                   timeout_o,
   output logic [CNT_W-1:0]       pulse_cnt_o
);

   logic [NUM_SENSORS-1:0] sync1_q, sync2_q;
   logic                   echo_prev_q;
   logic [CNT_W-1:0]       cycle_q, cycle_d;
   logic [CNT_W-1:0]       pulse_q, pulse_d;
   logic [CNT_W-1:0]       pulse_inc;
   logic                   echo_sel;
   logic                   echo_fall;
   logic                   window_end;

   assign echo_sel   = sync2_q[sel_id_i];
   assign echo_fall  = echo_prev_q & ~echo_sel;
   assign window_end = (cycle_q == CNT_W'(WINDOW_CYCLES - 1));

   // Counter updates and completion decode for the open window.
   always_comb begin
      pulse_inc = (echo_sel && (pulse_q != '1)) ? pulse_q + 1'b1 : pulse_q;
      cycle_d   = cycle_q;
      pulse_d   = pulse_q;
      if (start_i) begin
         cycle_d = '0;
         pulse_d = '0;
      end else if (run_i) begin
         cycle_d = cycle_q + 1'b1;
         pulse_d = pulse_inc;
      end
      done_o      = run_i & echo_fall & (pulse_q != '0);
      timeout_o   = run_i & window_end & ~done_o;
      // Includes the current cycle so a window ending with echo still high counts it.
      pulse_cnt_o = pulse_inc;
   end

   // Two-flop synchronizer, edge history and counters.
   always_ff @(posedge clk_50M) begin
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         echo_prev_q <= 1'b0;
         cycle_q     <= '0;
         pulse_q     <= '0;
      end else begin
         sync1_q     <= echo_rx_i;
         sync2_q     <= sync1_q;
         echo_prev_q <= echo_sel;
         cycle_q     <= cycle_d;
         pulse_q     <= pulse_d;
      end
   end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for four ultrasonic rangers: triggers one sensor at a time, times its
// echo, reports the result, then waits a holdoff before the next sensor.
// Optional per-sensor proximity alert enabled by defining ULTRASONIC_SCHED_ALERT_EN.
module ultrasonic_scheduler
   import ultrasonic_sched_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES   = DEF_TRIG_CYCLES,
   parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
   parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
   parameter int unsigned ALERT_THRESH  = DEF_ALERT_THRESH
) (
   input  logic                   clk_50M,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_SENSORS-1:0] sensor_mask,
   input  logic [NUM_SENSORS-1:0] echo_rx,
   output logic [NUM_SENSORS-1:0] trigger,
   output logic [CNT_W-1:0]       dist_data,
   output logic [ID_W-1:0]        dist_id,
   output logic                   dist_valid,
   output logic                   timeout,
   output logic [ID_W-1:0]        active_id,
   output logic [1:0]             state,
   output logic [NUM_SENSORS-1:0] alert
);

   sched_state_e     state_q, state_d;
   logic [ID_W-1:0]  active_q, active_d;
   logic [CNT_W-1:0] phase_q, phase_d;      // elapsed cycles in TRIG or GAP
   logic [CNT_W-1:0] dist_data_q, dist_data_d;
   logic [ID_W-1:0]  dist_id_q, dist_id_d;
   logic             dist_valid_q, dist_valid_d;
   logic             timeout_q, timeout_d;

   logic             timer_start, timer_run, timer_done, timer_timeout;
   logic [CNT_W-1:0] timer_pulse;

   // Kept outside the FSM block so the timer's done path does not loop back through it.
   assign timer_start = (state_q == StTrig) && (phase_q == CNT_W'(TRIG_CYCLES - 1));
   assign timer_run   = (state_q == StMeasure);

   us_echo_timer #(
      .WINDOW_CYCLES (WINDOW_CYCLES)
   ) u_echo_timer (
      .clk_50M     (clk_50M),
      .reset       (reset),
      .echo_rx_i   (echo_rx),
      .sel_id_i    (active_q),
      .start_i     (timer_start),
      .run_i       (timer_run),
      .done_o      (timer_done),
      .timeout_o   (timer_timeout),
      .pulse_cnt_o (timer_pulse)
   );

   // Next-state, sensor selection and result capture.
   always_comb begin
      state_d      = state_q;
      active_d     = active_q;
      phase_d      = phase_q;
      dist_data_d  = dist_data_q;
      dist_id_d    = dist_id_q;
      dist_valid_d = 1'b0;
      timeout_d    = timeout_q;
      case (state_q)
         StIdle: begin
            if (enable && (|sensor_mask)) begin
               active_d = next_sensor(active_q, sensor_mask, 1'b1);
               phase_d  = '0;
               state_d  = StTrig;
            end
         end
         StTrig: begin
            if (timer_start) begin
               phase_d = '0;
               state_d = StMeasure;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         StMeasure: begin
            // A real echo takes priority over a coincident window expiry.
            if (timer_done || timer_timeout) begin
               dist_valid_d = 1'b1;
               dist_data_d  = timer_pulse;
               dist_id_d    = active_q;
               timeout_d    = ~timer_done;
               phase_d      = '0;
               state_d      = StGap;
            end
         end
         StGap: begin
            if (phase_q == CNT_W'(GAP_CYCLES - 1)) begin
               phase_d = '0;
               if (|sensor_mask) begin
                  active_d = next_sensor(active_q, sensor_mask, 1'b0);
               end
               state_d = (enable && (|sensor_mask)) ? StTrig : StIdle;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Trigger decoded from state so a reset drops it on the same edge.
   always_comb begin
      trigger = '0;
      if (state_q == StTrig) begin
         trigger[active_q] = 1'b1;
      end
   end

   // Scheduler and result registers.
   always_ff @(posedge clk_50M) begin
      if (!reset) begin
         state_q      <= StIdle;
         active_q     <= '0;
         phase_q      <= '0;
         dist_data_q  <= '0;
         dist_id_q    <= '0;
         dist_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         phase_q      <= phase_d;
         dist_data_q  <= dist_data_d;
         dist_id_q    <= dist_id_d;
         dist_valid_q <= dist_valid_d;
         timeout_q    <= timeout_d;
      end
   end

   assign state      = state_q;
   assign active_id  = active_q;
   assign dist_data  = dist_data_q;
   assign dist_id    = dist_id_q;
   assign dist_valid = dist_valid_q;
   assign timeout    = timeout_q;

`ifdef ULTRASONIC_SCHED_ALERT_EN
   logic [NUM_SENSORS-1:0] alert_q, alert_d;

   // Refresh the reporting sensor's alert alongside each new result.
   always_comb begin
      alert_d = alert_q;
      if (dist_valid_d) begin
         alert_d[dist_id_d] = ~timeout_d && (dist_data_d > CNT_W'(ALERT_THRESH));
      end
   end

   // Alert flags register.
   always_ff @(posedge clk_50M) begin
      if (!reset) begin
         alert_q <= '0;
      end else begin
         alert_q <= alert_d;
      end
   end

   assign alert = alert_q;
`else
   logic unused_alert_thresh;
   assign unused_alert_thresh = ^ALERT_THRESH;
   assign alert = '0;
`endif

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with shortened timing (TRIG 10, WINDOW 2000, GAP 50).
module tb_ultrasonic_scheduler;

   localparam int unsigned TRIG_C = 10;
   localparam int unsigned WIN_C  = 2000;
   localparam int unsigned GAP_C  = 50;
`ifdef ULTRASONIC_SCHED_ALERT_EN
   localparam logic [3:0] ALERT_KEEP = 4'b1111;
`else
   localparam logic [3:0] ALERT_KEEP = 4'b0000;
`endif

   logic        clk_50M = 1'b0;
   logic        reset;
   logic        enable;
   logic [3:0]  sensor_mask;
   logic [3:0]  echo_rx;
   logic [3:0]  trigger;
   logic [21:0] dist_data;
   logic [1:0]  dist_id;
   logic        dist_valid;
   logic        timeout;
   logic [1:0]  active_id;
   logic [1:0]  state;
   logic [3:0]  alert;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 clk_50M = ~clk_50M;

   ultrasonic_scheduler #(
      .TRIG_CYCLES   (TRIG_C),
      .WINDOW_CYCLES (WIN_C),
      .GAP_CYCLES    (GAP_C),
      .ALERT_THRESH  (1200)
   ) dut (
      .clk_50M     (clk_50M),
      .reset       (reset),
      .enable      (enable),
      .sensor_mask (sensor_mask),
      .echo_rx     (echo_rx),
      .trigger     (trigger),
      .dist_data   (dist_data),
      .dist_id     (dist_id),
      .dist_valid  (dist_valid),
      .timeout     (timeout),
      .active_id   (active_id),
      .state       (state),
      .alert       (alert)
   );

   typedef struct {
      logic [3:0]  mask;      // sensor_mask applied before this visit
      logic [3:0]  echo_pat;  // echo lines driven at MEASURE entry
      int          echo_len;  // cycles the echo lines stay high (0 = none)
      logic        drop_en;   // deassert enable at MEASURE entry
      logic [1:0]  exp_id;
      logic [21:0] exp_data;
      logic        exp_to;
      int          exp_lat;   // cycles from MEASURE entry to dist_valid
      logic [3:0]  exp_alert; // alert after this result, alert logic present
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50M);
      #1;
   endtask

   task automatic run_visit(input int r, input vec_t v);
      int          k;
      int          trig_n;
      int          multi;
      int          lat;
      bit          got;
      logic [21:0] cap_data;
      logic [1:0]  cap_id;
      logic        cap_to;
      logic [1:0]  cap_state;
      logic [3:0]  cap_alert;
      sensor_mask = v.mask;
      k = 0;
      while (state !== 2'b01 && k < 3000) begin
         tick();
         k++;
      end
      check($sformatf("v%0d_reach_trig", r), 32'(state === 2'b01), 32'd1);
      check($sformatf("v%0d_active_id", r), 32'(active_id), 32'(v.exp_id));
      trig_n = 0;
      multi  = 0;
      k      = 0;
      while (state === 2'b01 && k < 100) begin
         if (trigger === (4'b0001 << v.exp_id)) trig_n++;
         if (!$onehot0(trigger)) multi++;
         tick();
         k++;
      end
      check($sformatf("v%0d_trig_len", r), 32'(trig_n), 32'(TRIG_C));
      check($sformatf("v%0d_trig_onehot", r), 32'(multi), 32'd0);
      check($sformatf("v%0d_reach_measure", r), 32'(state === 2'b10), 32'd1);
      if (v.drop_en) enable = 1'b0;
      if (v.echo_len > 0) echo_rx = v.echo_pat;
      k = 0; got = 1'b0; lat = 0;
      cap_data = '0; cap_id = '0; cap_to = 1'b0; cap_state = '0; cap_alert = '0;
      while (k < 4000 && !(got && k > v.echo_len && k > lat)) begin
         tick();
         k++;
         if (k == v.echo_len) echo_rx = 4'b0000;
         if (got && k == lat + 1) check($sformatf("v%0d_dv_pulse", r), 32'(dist_valid), 32'd0);
         if (dist_valid === 1'b1 && !got) begin
            got       = 1'b1;
            lat       = k;
            cap_data  = dist_data;
            cap_id    = dist_id;
            cap_to    = timeout;
            cap_state = state;
            cap_alert = alert;
         end
      end
      echo_rx = 4'b0000;
      check($sformatf("v%0d_dv_seen", r), 32'(got), 32'd1);
      if (got) begin
         check($sformatf("v%0d_dist_id", r), 32'(cap_id), 32'(v.exp_id));
         check($sformatf("v%0d_dist_data", r), 32'(cap_data), 32'(v.exp_data));
         check($sformatf("v%0d_timeout", r), 32'(cap_to), 32'(v.exp_to));
         check($sformatf("v%0d_latency", r), 32'(lat), 32'(v.exp_lat));
         check($sformatf("v%0d_state_gap", r), 32'(cap_state), 32'd3);
         check($sformatf("v%0d_alert", r), 32'(cap_alert), 32'(v.exp_alert & ALERT_KEEP));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int bad;
      // mask, echo_pat, echo_len, drop_en, exp_id, exp_data, exp_to, exp_lat, exp_alert
      vecs[0]  = '{4'b1111, 4'b0001,  300, 1'b0, 2'd0, 22'd300,  1'b0,  303, 4'b0000};
      vecs[1]  = '{4'b1010, 4'b0000,    0, 1'b0, 2'd1, 22'd0,    1'b1, 2000, 4'b0000};
      vecs[2]  = '{4'b1010, 4'b0000,    0, 1'b0, 2'd3, 22'd0,    1'b1, 2000, 4'b0000};
      vecs[3]  = '{4'b1010, 4'b0100,  200, 1'b0, 2'd1, 22'd0,    1'b1, 2000, 4'b0000};
      vecs[4]  = '{4'b1010, 4'b0000,    0, 1'b0, 2'd3, 22'd0,    1'b1, 2000, 4'b0000};
      vecs[5]  = '{4'b1010, 4'b0110,  150, 1'b0, 2'd1, 22'd150,  1'b0,  153, 4'b0000};
      vecs[6]  = '{4'b0001, 4'b0001,    1, 1'b0, 2'd0, 22'd1,    1'b0,    4, 4'b0000};
      vecs[7]  = '{4'b0001, 4'b0001, 2020, 1'b0, 2'd0, 22'd1998, 1'b1, 2000, 4'b0000};
      vecs[8]  = '{4'b0100, 4'b0100, 1500, 1'b0, 2'd2, 22'd1500, 1'b0, 1503, 4'b0100};
      vecs[9]  = '{4'b0100, 4'b0100,  800, 1'b0, 2'd2, 22'd800,  1'b0,  803, 4'b0000};
      vecs[10] = '{4'b0001, 4'b0001,  100, 1'b1, 2'd0, 22'd100,  1'b0,  103, 4'b0000};

      reset = 1'b0; enable = 1'b0; sensor_mask = 4'b0000; echo_rx = 4'b0000;
      repeat (3) tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_trigger", 32'(trigger), 32'd0);
      check("rst_dist_valid", 32'(dist_valid), 32'd0);
      check("rst_dist_data", 32'(dist_data), 32'd0);
      check("rst_dist_id", 32'(dist_id), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_active_id", 32'(active_id), 32'd0);
      check("rst_alert", 32'(alert), 32'd0);
      reset = 1'b1;

      // Enabled with an empty mask must stay idle.
      enable = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state !== 2'b00 || trigger !== 4'b0000) bad++;
      end
      check("empty_mask_idle", 32'(bad), 32'd0);

      for (int i = 0; i < 11; i++) run_visit(i, vecs[i]);

      // Enable was dropped during the last visit: expect IDLE after GAP and no triggers.
      k = 0;
      while (state === 2'b11 && k < 200) begin
         tick();
         k++;
      end
      check("drop_en_idle", 32'(state), 32'd0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (state !== 2'b00 || trigger !== 4'b0000 || dist_valid !== 1'b0) bad++;
      end
      check("drop_en_quiet", 32'(bad), 32'd0);
      check("hold_dist_data", 32'(dist_data), 32'd100);
      check("hold_dist_id", 32'(dist_id), 32'd0);
      check("hold_timeout", 32'(timeout), 32'd0);

      // Reset in the middle of a trigger pulse.
      enable = 1'b1;
      k = 0;
      while (state !== 2'b01 && k < 200) begin
         tick();
         k++;
      end
      check("midtrig_reach", 32'(state === 2'b01), 32'd1);
      repeat (4) tick();
      check("midtrig_trig_before", 32'(trigger), 32'd1);
      reset = 1'b0;
      tick();
      check("midtrig_trigger", 32'(trigger), 32'd0);
      check("midtrig_state", 32'(state), 32'd0);
      check("midtrig_dist_data", 32'(dist_data), 32'd0);
      check("midtrig_dist_valid", 32'(dist_valid), 32'd0);
      enable = 1'b0;
      tick();
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (dist_valid !== 1'b0 || state !== 2'b00 || trigger !== 4'b0000) bad++;
      end
      check("midtrig_no_result", 32'(bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
